// File: rtl/ipv4_pkg.sv
// ipv4_pkg: shared constants, error codes and FSM state type for the IPv4 receive stage.
package ipv4_pkg;

  localparam logic [3:0]  IPV4_VERSION = 4'd4;
  localparam logic [3:0]  IHL_MIN      = 4'd5;

  localparam logic [15:0] OFF_TOT_LEN  = 16'd2;
  localparam logic [15:0] OFF_PROTO    = 16'd9;
  localparam logic [15:0] OFF_SRC      = 16'd12;
  localparam logic [15:0] BASE_HDR_LEN = 16'd20;

  localparam logic [7:0]  PROTO_UDP    = 8'h11;
  localparam logic [7:0]  PROTO_TCP    = 8'h06;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_HDR   = 2'd1,
    ERR_CSUM  = 2'd2,
    ERR_TRUNC = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    OPT,
    DATA,
    DROP
  } state_t;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// ipv4_csum: ones'-complement header checksum accumulator, DATA_W/16 words per cycle.
// sum_ok reflects the accumulated value including the word(s) presented this cycle.
module ipv4_csum
  import ipv4_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic              sum_ok
);

  localparam int WORDS = DATA_W / 16;

  logic [15:0] acc;
  logic [15:0] sum;

  always_comb begin
    sum = clear ? '0 : acc;
    if (en) begin
      for (int unsigned j = 0; j < WORDS; j++) begin
        sum = ones_add(sum, {data[16*j +: 8], data[16*j+8 +: 8]});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= sum;
    end
  end

  assign sum_ok = (sum == 16'hFFFF);

endmodule

// File: rtl/ipv4_rx.sv
// ipv4_rx: IPv4 receive stage -- header parse/validate, option skip, pad trim, payload forward.
// Optional build macro IPV4_RX_CHECKSUM_EN enables header checksum verification.
module ipv4_rx
  import ipv4_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W/8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              crc_err_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              start_o,
  output logic              last_o,
  output logic [7:0]        protocol_o,
  output logic [31:0]       src_addr_o,
  output logic              cancel_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  localparam logic [15:0] BYTES16 = 16'(KEEP_W);

  state_t      state, nstate;
  err_code_t   err_code;

  logic [15:0] cnt, base, cnt_end, hdr_len, rem, take;
  logic [15:0] tot_len;
  logic [3:0]  ver, ihl;
  logic [7:0]  proto;
  logic [31:0] src;
  logic        sent, first, arm;
  logic [2:0]  arm_cnt;
  logic [KEEP_W-1:0] rem_mask;

  logic hdr_beat, hdr_any, hdr_bad, sum_ok;
  logic err_go, load_rem, fwd, frame_end, trunc, crc_hit;

  // The beat seen in IDLE is header bytes 0.., so the offset base is forced to 0 there.
  assign base     = (state == IDLE) ? '0 : cnt;
  assign cnt_end  = base + BYTES16;
  assign hdr_len  = {10'd0, ihl, 2'd0};
  assign hdr_beat = valid_i && (state == IDLE || state == HEAD);
  assign hdr_any  = hdr_beat || (valid_i && state == OPT);
  assign hdr_bad  = (ver != IPV4_VERSION) || (ihl < IHL_MIN) || (tot_len < hdr_len);

  assign frame_end = (state == DATA) && !valid_i;
  assign trunc     = frame_end && (rem != '0);
  assign fwd       = (state == DATA) && valid_i && (rem != '0);
  assign crc_hit   = crc_err_i && ((frame_end && sent && !trunc) || arm);

`ifdef IPV4_RX_CHECKSUM_EN
  ipv4_csum #(.DATA_W(DATA_W)) u_csum (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .en     (hdr_any),
    .data   (data_i),
    .sum_ok (sum_ok)
  );
`else
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    rem_mask = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      rem_mask[i] = (16'(i) < rem);
    end
    take = (rem < BYTES16) ? rem : BYTES16;
  end

  always_comb begin
    nstate   = state;
    err_go   = 1'b0;
    err_code = ERR_NONE;
    load_rem = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i) nstate = HEAD;
      end
      HEAD: begin
        if (!valid_i) begin
          err_go   = 1'b1;
          err_code = ERR_TRUNC;
          nstate   = IDLE;
        end else if (cnt_end == BASE_HDR_LEN) begin
          if (hdr_bad) begin
            err_go   = 1'b1;
            err_code = ERR_HDR;
            nstate   = DROP;
          end else if (ihl > IHL_MIN) begin
            nstate = OPT;
          end else if (!sum_ok) begin
            err_go   = 1'b1;
            err_code = ERR_CSUM;
            nstate   = DROP;
          end else begin
            load_rem = 1'b1;
            nstate   = DATA;
          end
        end
      end
      OPT: begin
        if (!valid_i) begin
          err_go   = 1'b1;
          err_code = ERR_TRUNC;
          nstate   = IDLE;
        end else if (cnt_end == hdr_len) begin
          if (!sum_ok) begin
            err_go   = 1'b1;
            err_code = ERR_CSUM;
            nstate   = DROP;
          end else begin
            load_rem = 1'b1;
            nstate   = DATA;
          end
        end
      end
      DATA: begin
        if (!valid_i) nstate = IDLE;
      end
      DROP: begin
        if (!valid_i) nstate = IDLE;
      end
      default: nstate = DROP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DROP;
    end else begin
      state <= nstate;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      ver        <= '0;
      ihl        <= '0;
      tot_len    <= '0;
      proto      <= '0;
      src        <= '0;
      rem        <= '0;
      sent       <= 1'b0;
      first      <= 1'b0;
      arm        <= 1'b0;
      arm_cnt    <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      keep_o     <= '0;
      start_o    <= 1'b0;
      last_o     <= 1'b0;
      protocol_o <= '0;
      src_addr_o <= '0;
      cancel_o   <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      valid_o  <= 1'b0;
      start_o  <= 1'b0;
      last_o   <= 1'b0;
      keep_o   <= '0;
      cancel_o <= trunc || crc_hit;
      err_o    <= err_go || trunc;
      if (trunc) begin
        err_code_o <= ERR_TRUNC;
      end else if (err_go) begin
        err_code_o <= err_code;
      end else begin
        err_code_o <= ERR_NONE;
      end

      if (hdr_any) cnt <= cnt_end;

      if (hdr_beat) begin
        for (int unsigned i = 0; i < KEEP_W; i++) begin
          if (base + 16'(i) == 16'd0) begin
            ver <= data_i[8*i+4 +: 4];
            ihl <= data_i[8*i +: 4];
          end
          if (base + 16'(i) == OFF_TOT_LEN)          tot_len[15:8] <= data_i[8*i +: 8];
          if (base + 16'(i) == OFF_TOT_LEN + 16'd1)  tot_len[7:0]  <= data_i[8*i +: 8];
          if (base + 16'(i) == OFF_PROTO)            proto         <= data_i[8*i +: 8];
          if (base + 16'(i) == OFF_SRC)              src[31:24]    <= data_i[8*i +: 8];
          if (base + 16'(i) == OFF_SRC + 16'd1)      src[23:16]    <= data_i[8*i +: 8];
          if (base + 16'(i) == OFF_SRC + 16'd2)      src[15:8]     <= data_i[8*i +: 8];
          if (base + 16'(i) == OFF_SRC + 16'd3)      src[7:0]      <= data_i[8*i +: 8];
        end
      end

      if (load_rem) begin
        rem   <= tot_len - hdr_len;
        first <= 1'b1;
        sent  <= 1'b0;
      end else if (fwd) begin
        valid_o <= 1'b1;
        data_o  <= data_i;
        keep_o  <= keep_i & rem_mask;
        start_o <= first;
        last_o  <= (rem <= BYTES16);
        rem     <= rem - take;
        first   <= 1'b0;
        sent    <= 1'b1;
        if (first) begin
          protocol_o <= proto;
          src_addr_o <= src;
        end
      end

      // The CRC verdict can trail into the next frame, so it is tracked apart from the FSM.
      if (frame_end) begin
        arm     <= sent && !trunc && !crc_err_i;
        arm_cnt <= 3'd4;
      end else if (arm) begin
        if (crc_err_i || arm_cnt == 3'd1) arm <= 1'b0;
        arm_cnt <= arm_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ipv4_rx.sv
// tb_ipv4_rx: directed self-checking bench for ipv4_rx (DATA_W=16).
// Honours IPV4_RX_CHECKSUM_EN for the bad-checksum expectation.
module tb_ipv4_rx;

  localparam int NORST = 1 << 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [15:0] data_i;
  logic [1:0]  keep_i;
  logic        crc_err_i;
  logic        valid_o;
  logic [15:0] data_o;
  logic [1:0]  keep_o;
  logic        start_o;
  logic        last_o;
  logic [7:0]  protocol_o;
  logic [31:0] src_addr_o;
  logic        cancel_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  ipv4_rx #(.DATA_W(16), .KEEP_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .keep_i     (keep_i),
    .crc_err_i  (crc_err_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .keep_o     (keep_o),
    .start_o    (start_o),
    .last_o     (last_o),
    .protocol_o (protocol_o),
    .src_addr_o (src_addr_o),
    .cancel_o   (cancel_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  logic [7:0]  ob [0:4095];
  int          nob = 0, nbeat = 0, nlast = 0, ncancel = 0, nerr = 0;
  int          start_at = 0, last_at = 0, cancel_cyc = 0;
  logic [1:0]  last_keep = '0;
  logic [1:0]  err_code = '0;

  always @(negedge clk) begin
    if (valid_o) begin
      for (int k = 0; k < 2; k++) begin
        if (keep_o[k] && nob < 4096) begin
          ob[nob] = data_o[8*k +: 8];
          nob++;
        end
      end
      nbeat++;
      if (start_o) start_at = nbeat;
      if (last_o) begin
        nlast++;
        last_at   = nbeat;
        last_keep = keep_o;
      end
    end
    if (cancel_o) begin
      ncancel++;
      cancel_cyc = cyc;
    end
    if (err_o) begin
      nerr++;
      err_code = err_code_o;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame construction
  logic [7:0]  fb [0:127];
  logic [15:0] hw [0:11];

  task automatic build(input int nw, input int tot, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < nw*2)   fb[i] = (i % 2 == 0) ? hw[i/2][15:8] : hw[i/2][7:0];
      else if (i < tot) fb[i] = 8'((i * 7 + 3) & 255);
      else            fb[i] = 8'hEE;
    end
  endtask

  task automatic hdr_a();
    hw = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, 16'hb861,
           16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7, 16'h0000, 16'h0000};
  endtask

  int nb_rst = 0, fall_cyc = 0, crc_cyc = 0;

  task automatic send(input int n, input int rst_from);
    for (int i = 0; i < n; i += 2) begin
      @(posedge clk); #1;
      reset = (i >= rst_from) && (i < rst_from + 4);
      if (i == rst_from + 2) begin
        check("rst_mid valid_o", 32'(valid_o), 32'd0);
        check("rst_mid src", src_addr_o, 32'd0);
        check("rst_mid proto", 32'(protocol_o), 32'd0);
        nb_rst = nbeat;
      end
      valid_i = 1'b1;
      data_i  = {(i + 1 < n) ? fb[i+1] : 8'h00, fb[i]};
      keep_i  = (i + 1 < n) ? 2'b11 : 2'b01;
    end
    @(posedge clk); #1;
    reset    = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;
    keep_i   = '0;
    fall_cyc = cyc;
  endtask

  task automatic pulse_crc(input int after);
    repeat (after) @(posedge clk);
    #1;
    crc_err_i = 1'b1;
    crc_cyc   = cyc;
    @(posedge clk); #1;
    crc_err_i = 1'b0;
  endtask

  int b0, o0, l0, c0, e0;

  task automatic snap();
    b0 = nbeat; o0 = nob; l0 = nlast; c0 = ncancel; e0 = nerr;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input string t, input int beats, input int hdr, input int plen,
                              input logic [1:0] lkeep);
    int mism = 0;
    check({t, " beats"}, nbeat - b0, beats);
    check({t, " start_pos"}, start_at, b0 + 1);
    check({t, " last_cnt"}, nlast - l0, 1);
    check({t, " last_pos"}, last_at, b0 + beats);
    check({t, " last_keep"}, 32'(last_keep), 32'(lkeep));
    check({t, " bytes"}, nob - o0, plen);
    for (int j = 0; j < plen; j++) if (ob[o0 + j] !== fb[hdr + j]) mism++;
    check({t, " payload"}, mism, 0);
    check({t, " err"}, nerr - e0, 0);
    check({t, " cancel"}, ncancel - c0, 0);
  endtask

  task automatic expect_drop(input string t, input logic [1:0] code);
    check({t, " beats"}, nbeat - b0, 0);
    check({t, " err"}, nerr - e0, 1);
    check({t, " code"}, 32'(err_code), 32'(code));
    check({t, " cancel"}, ncancel - c0, 0);
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; data_i = '0; keep_i = '0; crc_err_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset start_last", 32'({start_o, last_o}), 32'd0);
    check("reset err", 32'({err_o, err_code_o}), 32'd0);
    check("reset cancel", 32'(cancel_o), 32'd0);
    check("reset proto", 32'(protocol_o), 32'd0);
    check("reset src", src_addr_o, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Good frame: 95 payload bytes -> 48 beats, last keep 01
    hdr_a(); build(10, 115, 115);
    snap(); send(115, NORST); settle();
    expect_frame("good", 48, 20, 95, 2'b01);
    check("good proto_at_start", 32'(protocol_o), 32'h11);
    check("good src_held", src_addr_o, 32'hc0a80001);

    // Bad checksum
    hdr_a(); hw[5] = 16'hb862; build(10, 115, 115);
    snap(); send(115, NORST); settle();
`ifdef IPV4_RX_CHECKSUM_EN
    expect_drop("csum_bad", 2'd2);
`else
    expect_frame("csum_ignored", 48, 20, 95, 2'b01);
`endif

    // total_len 28 padded to 46 bytes -> 8 payload bytes in 4 beats
    hw = '{16'h4500, 16'h001c, 16'h0000, 16'h4000, 16'h4011, 16'hb8b8,
           16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7, 16'h0000, 16'h0000};
    build(10, 28, 46);
    snap(); send(46, NORST); settle();
    expect_frame("pad", 4, 20, 8, 2'b11);

    // IHL=6 with one option word; payload starts at byte 24
    hw = '{16'h4600, 16'h0022, 16'h0000, 16'h4000, 16'h4011, 16'hb5b0,
           16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7, 16'h0101, 16'h0101};
    build(12, 34, 46);
    snap(); send(46, NORST); settle();
    expect_frame("opts", 5, 24, 10, 2'b11);

    // Version 6 dropped; a later crc_err_i on it is ignored
    hdr_a(); hw[0] = 16'h6500; build(10, 115, 115);
    snap(); send(115, NORST); pulse_crc(1); settle();
    expect_drop("ver6", 2'd1);

    // Next good frame goes through normally
    hdr_a(); build(10, 115, 115);
    snap(); send(115, NORST); settle();
    expect_frame("after_ver6", 48, 20, 95, 2'b01);

    // Truncated 10 bytes early
    snap(); send(105, NORST); settle();
    check("trunc beats", nbeat - b0, 43);
    check("trunc no_last", nlast - l0, 0);
    check("trunc cancel", ncancel - c0, 1);
    check("trunc cancel_time", cancel_cyc, fall_cyc + 1);
    check("trunc err", nerr - e0, 1);
    check("trunc code", 32'(err_code), 32'd3);

    // crc_err_i after a good forwarded frame
    hw = '{16'h4500, 16'h001c, 16'h0000, 16'h4000, 16'h4011, 16'hb8b8,
           16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7, 16'h0000, 16'h0000};
    build(10, 28, 46);
    snap(); send(46, NORST); pulse_crc(1); settle();
    check("crc beats", nbeat - b0, 4);
    check("crc cancel", ncancel - c0, 1);
    check("crc cancel_time", cancel_cyc, crc_cyc + 1);
    check("crc no_err", nerr - e0, 0);

    // Reset in the middle of DATA; the rest of the frame is ignored
    hdr_a(); build(10, 115, 115);
    nb_rst = -1;
    snap(); send(115, 40); settle();
    check("rst_mid some_before", 32'(nb_rst > b0), 32'd1);
    check("rst_mid tail_beats", nbeat - nb_rst, 0);
    check("rst_mid err", nerr - e0, 0);
    check("rst_mid cancel", ncancel - c0, 0);

    // Recovery after reset
    hw = '{16'h4500, 16'h001c, 16'h0000, 16'h4000, 16'h4011, 16'hb8b8,
           16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7, 16'h0000, 16'h0000};
    build(10, 28, 46);
    snap(); send(46, NORST); settle();
    expect_frame("post_rst", 4, 20, 8, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
